// File: rtl/wide_add_seq.sv
// -----------------------------------------------------------------------------
// wide_add_seq -- multi-cycle wide-operand adder sequencer
//
// Computes {cout, sum} = a + b + cin over W = N*K bits. A single N-bit
// ripple-carry slice is reused once per clock. Slices are processed from the
// least significant upwards, and a carry register links each slice to the next.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start_valid  in   1   requester presents an operation on a/b/cin
//   start_ready  out  1   block can take an operation (IDLE only)
//   a, b         in   W   operands, captured on the accepting edge
//   cin          in   1   carry into slice 0, captured on the accepting edge
//   res_valid    out  1   sum/cout hold a finished result (DONE)
//   res_ready    in   1   consumer takes the result
//   sum          out  W   registered result
//   cout         out  1   registered carry out of the top slice
//   busy         out  1   operation in flight or result pending (RUN|DONE)
//
// Also contains rca_Nbit, the N-bit ripple-carry slice used by the sequencer.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// rca_Nbit -- purely combinational N-bit ripple-carry adder
//
// Ports
//   a, b   in   N   slice operands
//   cin    in   1   carry in
//   s      out  N   slice sum
//   cout   out  1   carry out of bit N-1
// -----------------------------------------------------------------------------
module rca_Nbit #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N-1:0] sum_s;
    logic         carry_s;

    // Bit-serial full-adder chain; carry_s is the running ripple carry.
    always_comb begin
        sum_s   = {N{1'b0}};
        carry_s = cin;
        for (int i = 0; i < N; i++) begin
            sum_s[i] = a[i] ^ b[i] ^ carry_s;
            carry_s  = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
        end
    end

    assign s    = sum_s;
    assign cout = carry_s;

endmodule

module wide_add_seq #(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [N*K-1:0]   a,
    input  logic [N*K-1:0]   b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N*K-1:0]   sum,
    output logic             cout,
    output logic             busy
);

    localparam int W     = N * K;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [IDX_W-1:0] idx_r;
    logic             carry_r;
    logic [W-1:0]     a_reg_r;
    logic [W-1:0]     b_reg_r;
    logic [W-1:0]     sum_r;
    logic             cout_r;

    logic             accept_s;
    logic             res_take_s;
    logic             last_slice_s;
    logic [N-1:0]     a_slice_s;
    logic [N-1:0]     b_slice_s;
    logic [N-1:0]     add_sum_s;
    logic             add_cout_s;

    // Handshake outputs are decoded directly from the registered state.
    assign start_ready  = (state_r == ST_IDLE);
    assign res_valid    = (state_r == ST_DONE);
    assign busy         = (state_r == ST_RUN) || (state_r == ST_DONE);

    assign accept_s     = start_valid && start_ready;
    assign res_take_s   = res_valid && res_ready;
    assign last_slice_s = (idx_r == LAST_IDX);

    // The one shared slice always looks at the slice selected by idx_r.
    assign a_slice_s = a_reg_r[idx_r*N +: N];
    assign b_slice_s = b_reg_r[idx_r*N +: N];

    rca_Nbit #(.N(N)) u_rca (
        .a    (a_slice_s),
        .b    (b_slice_s),
        .cin  (carry_r),
        .s    (add_sum_s),
        .cout (add_cout_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic. A start that coincides with the result handshake
    // in DONE is not seen here: it gets accepted from IDLE one cycle later.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_slice_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (res_take_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture, slice sequencing, carry chaining and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= 1'b0;
            a_reg_r <= {W{1'b0}};
            b_reg_r <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_reg_r <= a;
                        b_reg_r <= b;
                        carry_r <= cin;
                        idx_r   <= {IDX_W{1'b0}};
                        sum_r   <= {W{1'b0}};
                        cout_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sum_r[idx_r*N +: N] <= add_sum_s;
                    carry_r             <= add_cout_s;
                    if (last_slice_s) begin
                        cout_r <= add_cout_s;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // Result held; sum/cout also survive the return to IDLE.
                end
                default: begin
                    idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_wide_add_seq.sv
// -----------------------------------------------------------------------------
// tb_wide_add_seq -- directed self-checking bench for wide_add_seq (N=32, K=4)
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wide_add_seq;

    localparam int N = 32;
    localparam int K = 4;
    localparam int W = N * K;

    logic           clk;
    logic           rst_n;
    logic           start_valid;
    logic           start_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cin;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   sum;
    logic           cout;
    logic           busy;

    int n_cmp;
    int n_err;

    wide_add_seq #(.N(N), .K(K)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present an operation, let it be accepted, then scramble the inputs.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        a = av; b = bv; cin = cv; start_valid = 1'b1;
        chk("launch_ready", {{W{1'b0}}, start_ready}, {{W{1'b0}}, 1'b1});
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        a = rnd_w(); b = rnd_w(); cin = $urandom_range(1, 0);
        chk("launch_busy", {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
        chk("launch_no_rv", {{W{1'b0}}, res_valid}, {(W+1){1'b0}});
    endtask

    // Wait for res_valid, check latency and result. Called right after launch.
    task automatic wait_done(input string tag, input logic [W:0] expv);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!res_valid && lat < 20);
        chk({tag, "_lat"}, (W+1)'(lat), (W+1)'(K));
        chk({tag, "_res"}, {cout, sum}, expv);
    endtask

    // Hold off the consumer for 'stall' cycles, then take the result.
    task automatic drain(input string tag, input int stall, input logic [W:0] expv);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_hold_rv"}, {{W{1'b0}}, res_valid}, {{W{1'b0}}, 1'b1});
            chk({tag, "_hold_res"}, {cout, sum}, expv);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_taken"}, {{(W-1){1'b0}}, res_valid, start_ready}, {{(W-1){1'b0}}, 2'b01});
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic [W:0] expv, input int stall);
        res_ready = (stall == 0);
        launch(av, bv, cv);
        wait_done(tag, expv);
        drain(tag, stall, expv);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   rexp;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start_valid = 1'b0;
        res_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        // 1. Reset with inputs toggling, then idle after release.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start_valid = $urandom_range(1, 0);
            res_ready = $urandom_range(1, 0);
            a = rnd_w(); b = rnd_w(); cin = $urandom_range(1, 0);
            #1;
            chk("rst_flags", {{(W-2){1'b0}}, start_ready, res_valid, busy}, {{(W-2){1'b0}}, 3'b100});
            chk("rst_res", {cout, sum}, {(W+1){1'b0}});
        end
        @(negedge clk);
        start_valid = 1'b0; res_ready = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_flags", {{(W-2){1'b0}}, start_ready, res_valid, busy}, {{(W-2){1'b0}}, 3'b100});
            chk("idle_res", {cout, sum}, {(W+1){1'b0}});
        end

        // 2. Full carry ripple through all slices, then all zero.
        do_op("ripple", {W{1'b1}}, {W{1'b0}}, 1'b1, {1'b1, {W{1'b0}}}, 0);
        do_op("zero", {W{1'b0}}, {W{1'b0}}, 1'b0, {(W+1){1'b0}}, 0);

        // 3. Carry across the slice 0 / slice 1 boundary.
        do_op("boundary", 128'h0000_0000_0000_0000_0000_0001_FFFF_FFFF, 128'h1, 1'b0,
              {1'b0, 128'h0000_0000_0000_0000_0000_0002_0000_0000}, 0);

        // 4. Backpressure with start_valid pulsing during DONE.
        res_ready = 1'b0;
        launch(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               128'h1111_1111_1111_1111_1111_1111_1111_1111, 1'b0);
        wait_done("bp", {1'b0, 128'h1234_5678_9ABC_DF01_0FED_CBA9_8765_4321});
        for (int i = 0; i < 10; i++) begin
            a = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
            b = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
            cin = 1'b1;
            start_valid = i[0];
            @(negedge clk);
            chk("bp_flags", {{(W-2){1'b0}}, start_ready, res_valid, busy}, {{(W-2){1'b0}}, 3'b011});
            chk("bp_res", {cout, sum}, {1'b0, 128'h1234_5678_9ABC_DF01_0FED_CBA9_8765_4321});
        end
        start_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp_to_idle", {{(W-2){1'b0}}, start_ready, res_valid, busy}, {{(W-2){1'b0}}, 3'b100});
        chk("bp_res_kept", {cout, sum}, {1'b0, 128'h1234_5678_9ABC_DF01_0FED_CBA9_8765_4321});
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        chk("bp_new_acc", {{(W-1){1'b0}}, start_ready, busy}, {{(W-1){1'b0}}, 2'b01});
        wait_done("bp_new", {1'b1, 128'h1});
        drain("bp_new", 2, {1'b1, 128'h1});

        // 5. Reset after two RUN cycles discards the operation.
        res_ready = 1'b1;
        launch({W{1'b1}}, {W{1'b1}}, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", {{(W-2){1'b0}}, start_ready, res_valid, busy}, {{(W-2){1'b0}}, 3'b100});
        chk("mid_rst_res", {cout, sum}, {(W+1){1'b0}});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_norv", {{W{1'b0}}, res_valid}, {(W+1){1'b0}});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {{(W-2){1'b0}}, start_ready, res_valid, busy}, {{(W-2){1'b0}}, 3'b100});
        end
        do_op("post_rst", 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_0000_0000,
              128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0,
              {1'b0, 128'h0000_0001_0000_0000_0000_0000_0000_0000}, 1);

        // 6. Random operations against the arithmetic reference.
        for (int i = 0; i < 200; i++) begin
            ra = rnd_w();
            rb = rnd_w();
            if (i % 8 == 0) rb = ~ra;
            rc = $urandom_range(1, 0);
            rexp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_op("rand", ra, rb, rc, rexp, $urandom_range(3, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
